// File: rtl/uart_pkg.sv
// UART receiver shared definitions
// FSM encodings, oversampling constants and bit vote helper
package uart_pkg;

  localparam int OS_RATE = 16;
  localparam int OS_W    = 4;
  localparam int DIV_MIN = 4;

  localparam logic [OS_W-1:0] OS_S0   = 4'd7;
  localparam logic [OS_W-1:0] OS_S1   = 4'd8;
  localparam logic [OS_W-1:0] OS_S2   = 4'd9;
  localparam logic [OS_W-1:0] OS_LAST = 4'(OS_RATE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake bundle
// master drives word and status, slave returns ready
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output dout,
    output dout_valid,
    output frame_err,
    output parity_err,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  parity_err,
    output dout_ready
  );

endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator
// one-cycle tick every div clocks, restarted by clear
module uart_os_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clear && (cnt == div - 1'b1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver, parameterized frame format, 16x oversampled
// majority-voted bits, single-entry output holding register
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             rx_en,
  input  logic             RX,
  input  logic [DIV_W-1:0] div,
  output logic             overrun,
  output logic             busy,
  uart_rx_param_if.master  rx_if
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic [DIV_W-1:0] DMIN = DIV_W'(DIV_MIN);
  localparam logic [IDX_W-1:0] LAST_D = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_S = IDX_W'(STOP_BITS - 1);

  rx_state_e state, state_nx;

  logic rx_s1, rx_s2, rx_d, fall;
  logic [DIV_W-1:0] div_q;
  logic clear, tick;
  logic [OS_W-1:0] os_cnt;
  logic smp7, smp8, maj, at9, at15;
  logic [IDX_W-1:0] idx;
  logic idx_clr, idx_inc, last_data, last_stop;
  logic [DATA_BITS-1:0] shreg, dout_q;
  logic par_bit, ferr_acc, perr;
  logic done, take;
  logic valid_q, ferr_q, perr_q, ovr_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  uart_os_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .arst (arst),
    .clear(clear),
    .div  (div_q),
    .tick (tick)
  );

  assign at9  = tick && (os_cnt == OS_S2);
  assign at15 = tick && (os_cnt == OS_LAST);
  assign maj  = maj3(smp7, smp8, rx_s2);

  assign last_data = (idx == LAST_D);
  assign last_stop = (idx == LAST_S);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clear   = 1'b1;
        idx_clr = 1'b1;
        if (rx_en && fall) begin
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (at9 && maj) begin
          state_nx = ST_IDLE;
        end else if (at15) begin
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at15 && last_data) begin
          idx_clr  = 1'b1;
          state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end else if (at15) begin
          idx_inc = 1'b1;
        end
      end
      ST_PARITY: begin
        if (at15) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        // frame ends at the last stop vote so the next start edge is caught
        if (at9 && last_stop) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (at15) begin
          idx_inc = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      div_q    <= DMIN;
      os_cnt   <= '0;
      smp7     <= 1'b1;
      smp8     <= 1'b1;
      idx      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_nx == ST_START) begin
        div_q <= (div < DMIN) ? DMIN : div;
      end
      if (clear) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + 1'b1;
      end
      if (tick && os_cnt == OS_S0) begin
        smp7 <= rx_s2;
      end
      if (tick && os_cnt == OS_S1) begin
        smp8 <= rx_s2;
      end
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_DATA && at9) begin
        shreg <= {maj, shreg[DATA_BITS-1:1]};
      end
      if (state == ST_PARITY && at9) begin
        par_bit <= maj;
      end
      if (clear) begin
        ferr_acc <= 1'b0;
      end else if (state == ST_STOP && at9 && !maj) begin
        ferr_acc <= 1'b1;
      end
    end
  end

  assign perr = (PARITY_EN != 0) ? ((^shreg) ^ par_bit ^ ODD) : 1'b0;

  // a word consumed in the completion cycle makes room for the new one
  assign take = done && (!valid_q || rx_if.dout_ready);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= done && valid_q && !rx_if.dout_ready;
      if (take) begin
        dout_q  <= shreg;
        ferr_q  <= ferr_acc | ~maj;
        perr_q  <= perr;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.dout       = dout_q;
  assign rx_if.dout_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.parity_err = perr_q;
  assign overrun          = ovr_q;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param
// 8N1 receiver plus an 8E2 receiver on separate lines
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic        rx_en;
  logic        rx0, rx1;
  logic [15:0] div;
  logic        ovr0, ovr1, busy0, busy1;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();

  uart_rx_param dut0 (
    .clk    (clk),
    .arst   (arst),
    .rx_en  (rx_en),
    .RX     (rx0),
    .div    (div),
    .overrun(ovr0),
    .busy   (busy0),
    .rx_if  (if0)
  );

  uart_rx_param #(
    .PARITY_EN (1),
    .PARITY_ODD(0),
    .STOP_BITS (2)
  ) dut1 (
    .clk    (clk),
    .arst   (arst),
    .rx_en  (rx_en),
    .RX     (rx1),
    .div    (div),
    .overrun(ovr1),
    .busy   (busy1),
    .rx_if  (if1)
  );

  int vecs = 0;
  int errs = 0;
  int ovr_cnt0 = 0;
  int c0;
  int bc;
  logic [8:0] pd;

  always @(negedge clk) if (ovr0) ovr_cnt0++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ediv();
    return (div < 16'd4) ? 4 : int'(div);
  endfunction

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) rx0 = v;
    else rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  // one frame then one idle bit; nz marks data bits given a single-sample spike
  task automatic tx(input int sel, input logic [8:0] d, input int nb,
                    input logic pe, input logic pb, input logic [1:0] st,
                    input int ns, input logic [8:0] nz, input bit rdy);
    int ed, b;
    ed = ediv();
    b  = 16 * ed;
    drive(sel, 1'b0, b);
    for (int i = 0; i < nb; i++) begin
      if (nz[i]) begin
        drive(sel, d[i], 9 * ed - 2);
        drive(sel, ~d[i], 6);
        drive(sel, d[i], b - 9 * ed - 4);
      end else begin
        drive(sel, d[i], b);
      end
    end
    if (pe) drive(sel, pb, b);
    for (int i = 0; i < ns; i++) begin
      if (rdy && i == ns - 1) begin
        drive(sel, st[i], 2 + 10 * ed);
        if0.dout_ready = 1'b1;
        drive(sel, st[i], 1);
        if0.dout_ready = 1'b0;
        drive(sel, st[i], b - 3 - 10 * ed);
      end else begin
        drive(sel, st[i], b);
      end
    end
    drive(sel, 1'b1, b);
  endtask

  task automatic consume(input int sel);
    @(negedge clk);
    if (sel == 0) if0.dout_ready = 1'b1;
    else if1.dout_ready = 1'b1;
    @(negedge clk);
    if0.dout_ready = 1'b0;
    if1.dout_ready = 1'b0;
    if (sel == 0) chk("consume0", if0.dout_valid, 1'b0);
    else chk("consume1", if1.dout_valid, 1'b0);
  endtask

  initial begin
    arst = 1'b1;
    rx_en = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    div = 16'd8;
    if0.dout_ready = 1'b0;
    if1.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", if0.dout, 8'h00);
    chk("rst_valid", if0.dout_valid, 1'b0);
    chk("rst_ferr", if0.frame_err, 1'b0);
    chk("rst_perr", if0.parity_err, 1'b0);
    chk("rst_ovr", ovr0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    arst = 1'b0;
    repeat (4) @(negedge clk);

    div = 16'd54;
    tx(0, 9'h0A5, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("a5_dout", if0.dout, 8'hA5);
    chk("a5_valid", if0.dout_valid, 1'b1);
    chk("a5_ferr", if0.frame_err, 1'b0);
    chk("a5_perr", if0.parity_err, 1'b0);
    chk("a5_busy", busy0, 1'b0);
    consume(0);
    div = 16'd8;

    tx(1, 9'h007, 8, 1, 0, 2'b11, 2, 9'h0, 0);
    chk("par_bad_dout", if1.dout, 8'h07);
    chk("par_bad_perr", if1.parity_err, 1'b1);
    chk("par_bad_ferr", if1.frame_err, 1'b0);
    consume(1);
    tx(1, 9'h007, 8, 1, 1, 2'b11, 2, 9'h0, 0);
    chk("par_ok_perr", if1.parity_err, 1'b0);
    consume(1);
    tx(1, 9'h05A, 8, 1, 0, 2'b01, 2, 9'h0, 0);
    chk("stop2_dout", if1.dout, 8'h5A);
    chk("stop2_ferr", if1.frame_err, 1'b1);
    chk("stop2_perr", if1.parity_err, 1'b0);
    consume(1);

    tx(0, 9'h03C, 8, 0, 0, 2'b00, 1, 9'h0, 0);
    chk("fe_dout", if0.dout, 8'h3C);
    chk("fe_ferr", if0.frame_err, 1'b1);
    consume(0);
    tx(0, 9'h055, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("after_fe_dout", if0.dout, 8'h55);
    chk("after_fe_ferr", if0.frame_err, 1'b0);
    chk("after_fe_valid", if0.dout_valid, 1'b1);
    consume(0);

    drive(0, 1'b0, 3);
    drive(0, 1'b1, 20);
    chk("glitch_busy_hi", busy0, 1'b1);
    drive(0, 1'b1, 200);
    chk("glitch_valid", if0.dout_valid, 1'b0);
    chk("glitch_busy", busy0, 1'b0);

    tx(0, 9'h0C3, 8, 0, 0, 2'b11, 1, 9'b000100001, 0);
    chk("noise_dout", if0.dout, 8'hC3);
    chk("noise_ferr", if0.frame_err, 1'b0);
    consume(0);

    c0 = ovr_cnt0;
    tx(0, 9'h011, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    tx(0, 9'h022, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("ovr_dout", if0.dout, 8'h11);
    chk("ovr_valid", if0.dout_valid, 1'b1);
    chk("ovr_pulses", ovr_cnt0 - c0, 1);
    consume(0);
    c0 = ovr_cnt0;
    tx(0, 9'h011, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    tx(0, 9'h022, 8, 0, 0, 2'b11, 1, 9'h0, 1);
    chk("rdy_dout", if0.dout, 8'h22);
    chk("rdy_valid", if0.dout_valid, 1'b1);
    chk("rdy_pulses", ovr_cnt0 - c0, 0);
    consume(0);

    div = 16'd2;
    tx(0, 9'h096, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("clamp_dout", if0.dout, 8'h96);
    chk("clamp_ferr", if0.frame_err, 1'b0);
    consume(0);
    div = 16'd8;

    fork
      tx(0, 9'h05A, 8, 0, 0, 2'b11, 1, 9'h0, 0);
      begin
        repeat (400) @(negedge clk);
        rx_en = 1'b0;
      end
    join
    chk("en_mid_dout", if0.dout, 8'h5A);
    chk("en_mid_valid", if0.dout_valid, 1'b1);
    consume(0);
    tx(0, 9'h00F, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("en_off_valid", if0.dout_valid, 1'b0);
    chk("en_off_busy", busy0, 1'b0);
    rx_en = 1'b1;

    tx(0, 9'h03C, 8, 0, 0, 2'b00, 1, 9'h0, 0);
    chk("pre_rst_valid", if0.dout_valid, 1'b1);
    bc = 16 * ediv();
    pd = 9'h06B;
    drive(0, 1'b0, bc);
    for (int i = 0; i < 4; i++) drive(0, pd[i], bc);
    drive(0, pd[4], 40);
    arst = 1'b1;
    #1;
    chk("mid_rst_dout", if0.dout, 8'h00);
    chk("mid_rst_valid", if0.dout_valid, 1'b0);
    chk("mid_rst_ferr", if0.frame_err, 1'b0);
    chk("mid_rst_perr", if0.parity_err, 1'b0);
    chk("mid_rst_ovr", ovr0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (4) @(negedge clk);
    tx(0, 9'h081, 8, 0, 0, 2'b11, 1, 9'h0, 0);
    chk("post_rst_dout", if0.dout, 8'h81);
    chk("post_rst_valid", if0.dout_valid, 1'b1);
    chk("post_rst_ferr", if0.frame_err, 1'b0);
    chk("dut1_idle", busy1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL: parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL: parameter PARITY_EN, default 0, 1 = parity bit follows the data bits.
REQ-003 SHALL: parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-004 SHALL: parameter STOP_BITS, default 1, number of stop bits checked, legal 1..2.
REQ-005 SHALL: parameter DIV_W, default 16, width of the runtime divisor input.
REQ-006 SHALL: clk  input  1  single clock for all logic.
REQ-007 SHALL: arst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL: rx_en  input  1  enables detection of new start bits.
REQ-009 SHALL: RX  input  1  asynchronous serial line, idle high.
REQ-010 SHALL: div  input  DIV_W  clocks per 1/16-bit oversample tick; values below 4 are treated as 4.
REQ-011 SHALL: dout  output  DATA_BITS  received word, LSB first on the line.
REQ-012 SHALL: dout_valid  output  1  dout and status flags are valid.
REQ-013 SHALL: dout_ready  input  1  consumer accepts the word when high with dout_valid.
REQ-014 SHALL: frame_err, parity_err  output  1 each  status of the word in dout, qualified by dout_valid.
REQ-015 SHALL: overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 SHALL: pass RX through a two-flop synchronizer; all decoding uses the synchronized value only.
REQ-018 SHALL: tick generator asserts a one-cycle tick every div clocks; div is sampled only when leaving IDLE and held constant for the whole frame.
REQ-019 SHALL: run FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-020 SHALL: in IDLE with rx_en=1, a synchronized 1->0 transition moves the FSM to START and clears the tick and oversample counters.
REQ-021 SHALL: decide each bit by 2-of-3 majority of the samples at oversample counts 7, 8 and 9 (0..15 per bit).
REQ-022 SHALL: when the START majority is 1, treat it as a false start and return to IDLE with no output and no error.
REQ-023 SHALL: in DATA, shift DATA_BITS bits in LSB first, then go to PARITY or STOP at count 15 of the last bit.
REQ-024 SHALL: set parity_err when the XOR of the data bits and the parity bit, inverted when PARITY_ODD=1, is 1.
REQ-025 SHALL: set frame_err when any checked stop bit samples 0.
REQ-026 SHALL: finish the frame at the majority decision (count 9) of the last stop bit and enter IDLE in the next cycle, so back-to-back frames resynchronize.
REQ-027 SHALL: on frame completion, load dout, frame_err and parity_err and set dout_valid; the frame's output holding register is a single entry.
REQ-028 SHALL: clear dout_valid on the cycle after dout_valid && dout_ready, unless a new frame completes in that same cycle.
REQ-029 SHALL: when completion coincides with dout_valid && dout_ready, load the new word, keep dout_valid=1 and not signal overrun.
REQ-030 SHALL: when completion occurs with dout_valid=1 and dout_ready=0, keep the old word, drop the new one and pulse overrun.
REQ-031 SHALL: if rx_en falls mid-frame, complete the current frame normally and block only new starts.

Reset
REQ-032 SHALL: while arst=1, reset all registers immediately (FSM to IDLE, counters to 0, synchronizer flops to 1).
REQ-033 SHALL: during reset hold outputs dout=0, dout_valid=0, frame_err=0, parity_err=0, overrun=0 and busy=0.
REQ-034 SHALL: on arst mid-frame, discard the partial frame; the first falling edge after release starts a fresh frame.

Structure
REQ-035 SHALL: define the FSM state encodings and the oversample constants (16, sample points 7/8/9) in shared package uart_pkg.
REQ-036 SHALL: implement the tick generator as sub-module uart_os_tick (inputs clk, arst, clear, div; output tick).

Verification
REQ-037 SHALL: div=54, 8N1, 0xA5 at 115200 baud -> dout=0xA5, dout_valid=1, no errors, busy low after the stop bit.
REQ-038 SHALL: PARITY_EN=1, PARITY_ODD=0, byte 0x07 with parity bit 0 -> dout=0x07, parity_err=1.
REQ-039 SHALL: 0x3C with stop bit 0 -> frame_err=1; a following 0x55 frame is received cleanly.
REQ-040 SHALL: 3-clock-wide low glitch on RX while idle -> no dout_valid and FSM back in IDLE; one-sample noise spikes on data bits are rejected by the majority vote.
REQ-041 SHALL: two frames 0x11 then 0x22 with dout_ready=0 -> dout stays 0x11 and overrun pulses once; repeat with dout_ready pulsed at the completion cycle -> dout=0x22 and no overrun.
REQ-042 SHALL: arst asserted during bit 4 of a frame -> all outputs 0 at once; the next frame 0x81 is received correctly.
